// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection.
//
// Latches PC+4 and the fetched instruction. It compares the held
// instruction's rs/rt against the target of a load sitting in ID/EX.
// On a hit it holds the PC and IF/ID for STALL_CYCLES cycles and orders
// a control bubble into ID/EX. A branch/jump flush squashes the held slot.
// Saturating stall/flush event counters are kept for debug.
//
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_next_pc, i_instr     PC+4 and instruction from IF
//   i_flush                squash the held instruction (branch/jump taken)
//   i_id_ex_mem_read       ID/EX instruction is a load
//   i_id_ex_tar_reg        ID/EX load target register (rt)
//   o_next_pc, o_instr     registered PC+4 / instruction to ID
//   o_valid                held slot is a real instruction
//   o_pc_write             1 = PC may advance (combinational)
//   o_bubble               1 = zero ID/EX controls this cycle (combinational)
//   o_stall_cnt            saturating count of stall cycles
//   o_flush_cnt            saturating count of flush events
module if_id_hazard_stage #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_next_pc,
  input  logic [31:0]      i_instr,
  input  logic             i_flush,
  input  logic             i_id_ex_mem_read,
  input  logic [4:0]       i_id_ex_tar_reg,
  output logic [31:0]      o_next_pc,
  output logic [31:0]      o_instr,
  output logic             o_valid,
  output logic             o_pc_write,
  output logic             o_bubble,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [2:0] SCNT_INIT   = 3'(STALL_CYCLES - 1);
  localparam bit         MULTI_STALL = (STALL_CYCLES > 1);

  state_t     state;
  logic [2:0] scnt;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       hazard;
  logic       stalling;

  assign rs = o_instr[25:21];
  assign rt = o_instr[20:16];

  // rt is compared regardless of opcode: an I-type whose rt matches the
  // load target stalls too, which is harmless and keeps decode out of here.
  always_comb begin
    hazard   = o_valid & i_id_ex_mem_read & (i_id_ex_tar_reg != 5'd0) &
               ((i_id_ex_tar_reg == rs) | (i_id_ex_tar_reg == rt));
    stalling = ~i_flush & ((state == STALL) | hazard);
    // A flush lets the PC move to the branch target but still bubbles ID/EX.
    o_pc_write = ~stalling;
    o_bubble   = i_flush | stalling;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_next_pc   <= '0;
      o_instr     <= '0;
      o_valid     <= 1'b0;
      state       <= RUN;
      scnt        <= '0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else if (i_flush) begin
      o_next_pc <= '0;
      o_instr   <= '0;
      o_valid   <= 1'b0;
      state     <= RUN;
      scnt      <= '0;
      if (o_flush_cnt != '1) o_flush_cnt <= o_flush_cnt + 1'b1;
    end else if (state == STALL) begin
      // Hazard is not re-evaluated while the hold is in progress.
      if (o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 1'b1;
      scnt <= scnt - 3'd1;
      if (scnt == 3'd1) state <= RUN;
    end else if (hazard) begin
      // The detection cycle is the first held cycle; STALL covers the rest.
      if (o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (MULTI_STALL) begin
        state <= STALL;
        scnt  <= SCNT_INIT;
      end
    end else begin
      o_next_pc <= i_next_pc;
      o_instr   <= i_instr;
      o_valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Scoreboard bench for if_id_hazard_stage. Three instances:
//   dut0: STALL_CYCLES=1, CNT_W=16
//   dut1: STALL_CYCLES=3, CNT_W=16
//   dut2: STALL_CYCLES=3, CNT_W=2
// Stimulus processes drive inputs just after the rising edge and queue the
// hand-computed outputs for that cycle; the monitor samples on the falling
// edge and compares.
module tb_if_id_hazard_stage;

  localparam logic [31:0] ADD   = 32'h012A4020; // add $8,$9,$10: rs=9 rt=10
  localparam int unsigned LIMIT = 2000;

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        v;
    logic        pcw;
    logic        bub;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic        clk;
  logic [31:0] cyc;
  exp_t        q[$];
  int unsigned applied;
  int unsigned miscompares;
  bit          timed_out;
  bit          done[3];

  logic        rst_n[3];
  logic [31:0] next_pc[3];
  logic [31:0] instr[3];
  logic        flush[3];
  logic        mr[3];
  logic [4:0]  tar[3];

  logic [31:0] a_pc[3];
  logic [31:0] a_instr[3];
  logic        a_v[3];
  logic        a_pcw[3];
  logic        a_bub[3];
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;
  logic [31:0] a_sc[3];
  logic [31:0] a_fc[3];

  assign a_sc[0] = 32'(sc0);
  assign a_fc[0] = 32'(fc0);
  assign a_sc[1] = 32'(sc1);
  assign a_fc[1] = 32'(fc1);
  assign a_sc[2] = 32'(sc2);
  assign a_fc[2] = 32'(fc2);

  if_id_hazard_stage #(.STALL_CYCLES(1), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_next_pc(next_pc[0]), .i_instr(instr[0]),
    .i_flush(flush[0]), .i_id_ex_mem_read(mr[0]), .i_id_ex_tar_reg(tar[0]),
    .o_next_pc(a_pc[0]), .o_instr(a_instr[0]), .o_valid(a_v[0]),
    .o_pc_write(a_pcw[0]), .o_bubble(a_bub[0]),
    .o_stall_cnt(sc0), .o_flush_cnt(fc0));

  if_id_hazard_stage #(.STALL_CYCLES(3), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_next_pc(next_pc[1]), .i_instr(instr[1]),
    .i_flush(flush[1]), .i_id_ex_mem_read(mr[1]), .i_id_ex_tar_reg(tar[1]),
    .o_next_pc(a_pc[1]), .o_instr(a_instr[1]), .o_valid(a_v[1]),
    .o_pc_write(a_pcw[1]), .o_bubble(a_bub[1]),
    .o_stall_cnt(sc1), .o_flush_cnt(fc1));

  if_id_hazard_stage #(.STALL_CYCLES(3), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_next_pc(next_pc[2]), .i_instr(instr[2]),
    .i_flush(flush[2]), .i_id_ex_mem_read(mr[2]), .i_id_ex_tar_reg(tar[2]),
    .o_next_pc(a_pc[2]), .o_instr(a_instr[2]), .o_valid(a_v[2]),
    .o_pc_write(a_pcw[2]), .o_bubble(a_bub[2]),
    .o_stall_cnt(sc2), .o_flush_cnt(fc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input int unsigned d, input logic [31:0] pc, input logic [31:0] ins,
                      input logic v, input logic pcw, input logic bub,
                      input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    e.dut = 2'(d); e.tag = cyc; e.pc = pc; e.instr = ins; e.v = v;
    e.pcw = pcw; e.bub = bub; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic do_reset(input int unsigned d);
    rst_n[d] = 1'b0; instr[d] = 32'hFFFFFFFF; flush[d] = 1'b1;
    next_pc[d] = 32'h1234; mr[d] = 1'b0; tar[d] = 5'd0;
    tick();
    tick();
    rst_n[d] = 1'b1; flush[d] = 1'b0; next_pc[d] = 32'h4; instr[d] = ADD;
  endtask

  task automatic chk(input int unsigned d, input string f, input logic [31:0] got,
                     input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL dut%0d %s cycle %0d: got %h expected %h", d, f, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() != 0 && q[0].tag <= cyc) begin
      e = q.pop_front();
      if (e.tag != cyc) begin
        miscompares++;
        $display("FAIL stale dut%0d: tag %0d at cycle %0d", e.dut, e.tag, cyc);
      end else begin
        chk(32'(e.dut), "next_pc",   a_pc[e.dut],          e.pc);
        chk(32'(e.dut), "instr",     a_instr[e.dut],       e.instr);
        chk(32'(e.dut), "valid",     32'(a_v[e.dut]),      32'(e.v));
        chk(32'(e.dut), "pc_write",  32'(a_pcw[e.dut]),    32'(e.pcw));
        chk(32'(e.dut), "bubble",    32'(a_bub[e.dut]),    32'(e.bub));
        chk(32'(e.dut), "stall_cnt", a_sc[e.dut],          e.sc);
        chk(32'(e.dut), "flush_cnt", a_fc[e.dut],          e.fc);
      end
    end
    if (!timed_out && cyc > LIMIT && !(done[0] && done[1] && done[2])) begin
      timed_out = 1'b1;
      miscompares++;
      $display("FAIL timeout: got cycle %0d expected all done by %0d", cyc, LIMIT);
    end
  end

  // dut0: single-cycle stall, false-stall filters, rt match, flush
  initial begin
    do_reset(0);
    want(0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    want(0, 32'h4, ADD, 1, 1, 0, 0, 0);
    tick();
    mr[0] = 1'b1; tar[0] = 5'd9; next_pc[0] = 32'h8;
    want(0, 32'h4, ADD, 1, 0, 1, 0, 0);
    tick();
    mr[0] = 1'b0;
    want(0, 32'h4, ADD, 1, 1, 0, 1, 0);
    tick();
    mr[0] = 1'b1; tar[0] = 5'd0;
    want(0, 32'h8, ADD, 1, 1, 0, 1, 0);
    tick();
    mr[0] = 1'b0; tar[0] = 5'd9;
    want(0, 32'h8, ADD, 1, 1, 0, 1, 0);
    tick();
    mr[0] = 1'b1; tar[0] = 5'd11;
    want(0, 32'h8, ADD, 1, 1, 0, 1, 0);
    tick();
    tar[0] = 5'd10;
    want(0, 32'h8, ADD, 1, 0, 1, 1, 0);
    tick();
    mr[0] = 1'b0; flush[0] = 1'b1;
    want(0, 32'h8, ADD, 1, 1, 1, 2, 0);
    tick();
    flush[0] = 1'b0; mr[0] = 1'b1; tar[0] = 5'd9;
    want(0, 0, 0, 0, 1, 0, 2, 1);
    tick();
    mr[0] = 1'b0;
    want(0, 32'h8, ADD, 1, 1, 0, 2, 1);
    done[0] = 1'b1;
  end

  // dut1: three-cycle stall, then flush in the second stall cycle
  initial begin
    do_reset(1);
    want(1, 0, 0, 0, 1, 0, 0, 0);
    tick();
    mr[1] = 1'b1; tar[1] = 5'd9;
    want(1, 32'h4, ADD, 1, 0, 1, 0, 0);
    tick();
    mr[1] = 1'b0;
    want(1, 32'h4, ADD, 1, 0, 1, 1, 0);
    tick();
    want(1, 32'h4, ADD, 1, 0, 1, 2, 0);
    tick();
    next_pc[1] = 32'h8;
    want(1, 32'h4, ADD, 1, 1, 0, 3, 0);
    tick();
    mr[1] = 1'b1;
    want(1, 32'h8, ADD, 1, 0, 1, 3, 0);
    tick();
    mr[1] = 1'b0; flush[1] = 1'b1;
    want(1, 32'h8, ADD, 1, 1, 1, 4, 0);
    tick();
    flush[1] = 1'b0;
    want(1, 0, 0, 0, 1, 0, 4, 1);
    tick();
    want(1, 32'h8, ADD, 1, 1, 0, 4, 1);
    done[1] = 1'b1;
  end

  // dut2: flush counter saturation at 2 bits, reset in the middle of a stall
  initial begin
    do_reset(2);
    flush[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      want(2, 0, 0, 0, 1, 1, 0, (i < 3) ? 32'(i) : 32'd3);
      tick();
    end
    flush[2] = 1'b0;
    want(2, 0, 0, 0, 1, 0, 0, 3);
    tick();
    mr[2] = 1'b1; tar[2] = 5'd10;
    want(2, 32'h4, ADD, 1, 0, 1, 0, 3);
    tick();
    rst_n[2] = 1'b0;
    want(2, 32'h4, ADD, 1, 0, 1, 1, 3);
    tick();
    rst_n[2] = 1'b1; mr[2] = 1'b0;
    want(2, 0, 0, 0, 1, 0, 0, 0);
    tick();
    want(2, 32'h4, ADD, 1, 1, 0, 0, 0);
    done[2] = 1'b1;
  end

  initial begin
    wait ((done[0] && done[1] && done[2]) || timed_out);
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
